// File: rtl/sync_reg_arb.sv
// Round-robin arbiter feeding one shared SYNC_REG crossing from NCH in_clk-domain sources.
// One holding slot per channel; grants are paced GAP cycles apart so the crossing handshake is never overrun.
module sync_reg_arb #(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int GAP = 8,
    localparam int CW = $clog2(NCH)
) (
    input  logic              in_clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req_strobe,
    input  logic [NCH*DW-1:0] req_data,
    input  logic              ovfl_clr,
    output logic [NCH-1:0]    pend,
    output logic [NCH-1:0]    ovfl,
    output logic              sr_strobe,
    output logic [CW+DW-1:0]  sr_reg,
    output logic              idle
);

    localparam int GW = $clog2(GAP);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state;
    logic [GW-1:0]  cnt;
    logic [CW-1:0]  last;
    logic [DW-1:0]  slot [NCH];

    logic           grant;
    logic           grant_found;
    logic [CW-1:0]  grant_idx;
    logic [CW-1:0]  idx;
    logic [NCH-1:0] grant_vec;
    logic [NCH-1:0] ovfl_set;

    // First pending channel after 'last', wrapping; k == NCH wraps back onto 'last' itself.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last;
        idx         = last;
        for (int k = 1; k <= NCH; k++) begin
            idx = last + CW'(k);
            if (!grant_found && pend[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
        grant = (state == IDLE) && grant_found;
        for (int i = 0; i < NCH; i++) begin
            grant_vec[i] = grant && (grant_idx == CW'(i));
            ovfl_set[i]  = req_strobe[i] && pend[i] && !grant_vec[i];
        end
    end

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
            ovfl <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // A repost in the grant cycle refills the slot the grant is emptying.
                if (req_strobe[i] && (!pend[i] || grant_vec[i])) begin
                    slot[i] <= req_data[i*DW +: DW];
                    pend[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            ovfl <= (ovfl & ~{NCH{ovfl_clr}}) | ovfl_set;
        end
    end

    // Loading GAP-2 makes HOLD last GAP-1 cycles, so grants land exactly GAP cycles apart.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= CW'(NCH - 1);
            sr_strobe <= 1'b0;
            sr_reg    <= '0;
        end else begin
            sr_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        sr_strobe <= 1'b1;
                        sr_reg    <= {grant_idx, slot[grant_idx]};
                        last      <= grant_idx;
                        cnt       <= GW'(GAP - 2);
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign idle = (state == IDLE) && (pend == '0);

endmodule
